// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: func3 codes, FSM encoding and
// the byte-lane mask helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  function automatic logic [3:0] base_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Shifts a (up to two-word) raw read down by the byte offset, truncates to the
// access width and sign/zero-extends it.
module load_align_extend
  import lsu_pkg::*;
(
  input  logic [63:0] i_raw,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;
  assign w_shift = 32'(i_raw >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    case (i_func3)
      F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_data = w_shift;
      F3_BU:   o_data = {24'b0, w_shift[7:0]};
      F3_HU:   o_data = {16'b0, w_shift[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end: lane-aligns stores, extracts/extends loads and splits
// word-crossing accesses into two beats while stalling upstream.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqIsLoad,
  input  logic                  reqIsStore,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [31:0]           reqStoreData,
  input  logic [4:0]            reqRd,
  output logic                  memoryReadEnable,
  output logic                  memoryWriteEnable,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [3:0]            memoryByteEnable,
  output logic [31:0]           memoryWriteData,
  input  logic [31:0]           memoryReadData,
  output logic                  respValid,
  output logic                  respRegWrite,
  output logic [4:0]            respRd,
  output logic [31:0]           respData,
  output logic                  respFault
);

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_func3;
  logic [4:0]            r_rd;
  logic                  r_isLoad;
  logic [3:0]            r_beHi;
  logic [31:0]           r_wideHi;
  logic [31:0]           r_lowWord;

  logic [1:0]  w_off;
  logic [7:0]  w_mask8;
  logic [63:0] w_wide;
  logic        w_cross, w_accept, w_illegal, w_go;
  logic [ADDR_WIDTH-1:0] w_addr1, w_addr2;
  logic [63:0] w_raw;
  logic [1:0]  w_alOff;
  logic [2:0]  w_alF3;
  logic [31:0] w_ldData;

  assign w_off   = reqAddress[1:0];
  assign w_mask8 = {4'b0000, base_mask(func3)} << w_off;
  assign w_wide  = {32'b0, reqStoreData} << {w_off, 3'b000};
  assign w_cross = |w_mask8[7:4];
  assign w_addr1 = {reqAddress[ADDR_WIDTH-1:2], 2'b00};
  assign w_addr2 = {r_addr[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);

  // Only IDLE accepts; a crossing access is illegal when splitting is disabled.
  assign w_accept  = reqValid & (reqIsLoad | reqIsStore) & (r_state == IDLE);
  assign w_illegal = (reqIsLoad & reqIsStore) |
                     (reqIsLoad & ~legal_load(func3)) |
                     (reqIsStore & ~legal_store(func3)) |
                     (w_cross & (ALLOW_MISALIGNED == 0));
  assign w_go      = w_accept & ~w_illegal;

  // One extractor serves both beats; SECOND stitches the two words together.
  assign w_raw   = (r_state == SECOND) ? {memoryReadData, r_lowWord} : {32'b0, memoryReadData};
  assign w_alOff = (r_state == SECOND) ? r_addr[1:0] : w_off;
  assign w_alF3  = (r_state == SECOND) ? r_func3 : func3;

  load_align_extend u_align (
    .i_raw   (w_raw),
    .i_off   (w_alOff),
    .i_func3 (w_alF3),
    .o_data  (w_ldData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    reqReady          = 1'b0;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b0;
    memoryAddress     = '0;
    memoryByteEnable  = '0;
    memoryWriteData   = '0;
    case (r_state)
      IDLE: begin
        reqReady = 1'b1;
        if (w_go) begin
          memoryReadEnable  = reqIsLoad;
          memoryWriteEnable = reqIsStore;
          memoryAddress     = w_addr1;
          memoryByteEnable  = w_mask8[3:0];
          memoryWriteData   = w_wide[31:0];
          if (w_cross) w_next = SECOND;
        end
      end
      SECOND: begin
        memoryReadEnable  = r_isLoad;
        memoryWriteEnable = ~r_isLoad;
        memoryAddress     = w_addr2;
        memoryByteEnable  = r_beHi;
        memoryWriteData   = r_wideHi;
        w_next            = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_func3   <= '0;
      r_rd      <= '0;
      r_isLoad  <= 1'b0;
      r_beHi    <= '0;
      r_wideHi  <= '0;
      r_lowWord <= '0;
    end else if (w_go && w_cross) begin
      r_addr    <= reqAddress;
      r_func3   <= func3;
      r_rd      <= reqRd;
      r_isLoad  <= reqIsLoad;
      r_beHi    <= w_mask8[7:4];
      r_wideHi  <= w_wide[63:32];
      r_lowWord <= memoryReadData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      respValid    <= 1'b0;
      respRegWrite <= 1'b0;
      respFault    <= 1'b0;
      respRd       <= '0;
      respData     <= '0;
    end else begin
      respValid    <= 1'b0;
      respRegWrite <= 1'b0;
      respFault    <= 1'b0;
      if (r_state == SECOND) begin
        respValid    <= 1'b1;
        respRegWrite <= r_isLoad;
        respRd       <= r_rd;
        respData     <= r_isLoad ? w_ldData : 32'b0;
      end else if (w_accept && w_illegal) begin
        respValid <= 1'b1;
        respFault <= 1'b1;
        respRd    <= reqRd;
        respData  <= '0;
      end else if (w_go && !w_cross) begin
        respValid    <= 1'b1;
        respRegWrite <= reqIsLoad;
        respRd       <= reqRd;
        respData     <= reqIsLoad ? w_ldData : 32'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Vector table plus hand sequences against a byte-lane memory model; responses
// are matched in order through an expectation queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock, reset;
  logic        reqValid, reqIsLoad, reqIsStore;
  logic [2:0]  func3;
  logic [31:0] reqAddress, reqStoreData;
  logic [4:0]  reqRd;

  logic        reqReady, memoryReadEnable, memoryWriteEnable;
  logic [31:0] memoryAddress, memoryWriteData, memoryReadData;
  logic [3:0]  memoryByteEnable;
  logic        respValid, respRegWrite, respFault;
  logic [4:0]  respRd;
  logic [31:0] respData;

  logic        reqReady2, memoryReadEnable2, memoryWriteEnable2;
  logic [31:0] memoryAddress2, memoryWriteData2, memoryReadData2;
  logic [3:0]  memoryByteEnable2;
  logic        respValid2, respRegWrite2, respFault2;
  logic [4:0]  respRd2;
  logic [31:0] respData2;

  load_store_unit #(.ALLOW_MISALIGNED(1), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqIsLoad(reqIsLoad), .reqIsStore(reqIsStore), .func3(func3),
    .reqAddress(reqAddress), .reqStoreData(reqStoreData), .reqRd(reqRd),
    .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
    .memoryAddress(memoryAddress), .memoryByteEnable(memoryByteEnable),
    .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData),
    .respValid(respValid), .respRegWrite(respRegWrite), .respRd(respRd),
    .respData(respData), .respFault(respFault)
  );

  load_store_unit #(.ALLOW_MISALIGNED(0), .ADDR_WIDTH(32)) dut_nomis (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady2),
    .reqIsLoad(reqIsLoad), .reqIsStore(reqIsStore), .func3(func3),
    .reqAddress(reqAddress), .reqStoreData(reqStoreData), .reqRd(reqRd),
    .memoryReadEnable(memoryReadEnable2), .memoryWriteEnable(memoryWriteEnable2),
    .memoryAddress(memoryAddress2), .memoryByteEnable(memoryByteEnable2),
    .memoryWriteData(memoryWriteData2), .memoryReadData(memoryReadData2),
    .respValid(respValid2), .respRegWrite(respRegWrite2), .respRd(respRd2),
    .respData(respData2), .respFault(respFault2)
  );

  // Data memory driven only by the main DUT.
  logic [31:0] mem [0:63];
  assign memoryReadData  = mem[memoryAddress[7:2]];
  assign memoryReadData2 = mem[memoryAddress2[7:2]];
  always @(posedge clock) begin
    if (memoryWriteEnable)
      for (int i = 0; i < 4; i++)
        if (memoryByteEnable[i]) mem[memoryAddress[7:2]][8*i +: 8] <= memoryWriteData[8*i +: 8];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit l, s;
    logic [2:0] f3;
    logic [31:0] a, sd;
    logic [4:0] rd;
    bit cr;
    logic [3:0] be1;
    logic [31:0] wd1;
    logic [3:0] be2;
    logic [31:0] wd2, edata;
    bit flt;
  } vec_t;

  typedef struct {
    bit rw;
    logic [4:0] rd;
    logic [31:0] data;
    bit flt;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  function automatic vec_t mkv(bit l, bit s, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                               logic [4:0] rd, bit cr, logic [3:0] be1, logic [31:0] wd1,
                               logic [3:0] be2, logic [31:0] wd2, logic [31:0] edata, bit flt);
    vec_t v;
    v.l = l; v.s = s; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.cr = cr;
    v.be1 = be1; v.wd1 = wd1; v.be2 = be2; v.wd2 = wd2; v.edata = edata; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge clock);
    #1;
  endtask

  // Every response is drained here, so all checking lives in one process.
  task automatic at_neg();
    exp_t e;
    @(negedge clock);
    if (respValid) begin
      if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("resp_regwrite", 32'(respRegWrite), 32'(e.rw));
        chk("resp_fault", 32'(respFault), 32'(e.flt));
        chk("resp_data", respData, e.data);
        if (e.rw) chk("resp_rd", 32'(respRd), 32'(e.rd));
      end
    end
  endtask

  task automatic drive(input vec_t v);
    reqValid = 1'b1; reqIsLoad = v.l; reqIsStore = v.s; func3 = v.f3;
    reqAddress = v.a; reqStoreData = v.sd; reqRd = v.rd;
  endtask

  task automatic expect_resp(input vec_t v);
    exp_t e;
    if (v.l || v.s) begin
      e.rw = v.l && !v.flt; e.rd = v.rd; e.flt = v.flt;
      e.data = e.rw ? v.edata : 32'h0;
      q.push_back(e);
    end
  endtask

  task automatic issue(input vec_t v);
    logic [31:0] wa;
    wa = v.a & 32'hFFFF_FFFC;
    drive(v);
    expect_resp(v);
    at_neg();
    chk("ready_b1", 32'(reqReady), 32'd1);
    if (v.flt || !(v.l || v.s)) begin
      chk("rd_en_off", 32'(memoryReadEnable), 32'd0);
      chk("wr_en_off", 32'(memoryWriteEnable), 32'd0);
    end else begin
      chk("rd_en_b1", 32'(memoryReadEnable), 32'(v.l));
      chk("wr_en_b1", 32'(memoryWriteEnable), 32'(v.s));
      chk("addr_b1", memoryAddress, wa);
      chk("be_b1", 32'(memoryByteEnable), 32'(v.be1));
      if (v.s) chk("wdata_b1", memoryWriteData, v.wd1);
    end
    if (v.cr) begin
      chk("nomis_strobes", 32'(memoryReadEnable2 | memoryWriteEnable2), 32'd0);
      at_pos();
      at_neg();
      chk("ready_b2", 32'(reqReady), 32'd0);
      chk("rd_en_b2", 32'(memoryReadEnable), 32'(v.l));
      chk("wr_en_b2", 32'(memoryWriteEnable), 32'(v.s));
      chk("addr_b2", memoryAddress, wa + 32'd4);
      chk("be_b2", 32'(memoryByteEnable), 32'(v.be2));
      if (v.s) chk("wdata_b2", memoryWriteData, v.wd2);
      chk("nomis_fault", 32'(respValid2 & respFault2), 32'd1);
    end
    at_pos();
  endtask

  task automatic idle_cycle();
    reqValid = 1'b0; reqIsLoad = 1'b0; reqIsStore = 1'b0;
    at_neg();
    at_pos();
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; reqValid = 1'b0; reqIsLoad = 1'b0; reqIsStore = 1'b0;
    func3 = '0; reqAddress = '0; reqStoreData = '0; reqRd = '0;

    //    l  s  f3     addr     sdata         rd  cr be1      wd1           be2      wd2           edata         flt
    tbl.push_back(mkv(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 0,  0, 4'b1111, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_W,  32'h10, 32'h0,        7,  0, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mkv(0, 1, F3_B,  32'h23, 32'h80,       0,  0, 4'b1000, 32'h80000000, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_B,  32'h23, 32'h0,        8,  0, 4'b1000, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mkv(1, 0, F3_BU, 32'h23, 32'h0,        9,  0, 4'b1000, 32'h0,        4'b0000, 32'h0,        32'h00000080, 0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h22, 32'h11223344, 0,  1, 4'b1100, 32'h33440000, 4'b0011, 32'h00001122, 32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_W,  32'h22, 32'h0,        10, 1, 4'b1100, 32'h0,        4'b0011, 32'h0,        32'h11223344, 0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h0C, 32'hAB000000, 0,  0, 4'b1111, 32'hAB000000, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h10, 32'h000000CD, 0,  0, 4'b1111, 32'h000000CD, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_H,  32'h0F, 32'h0,        11, 1, 4'b1000, 32'h0,        4'b0001, 32'h0,        32'hFFFFCDAB, 0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h30, 32'h0,        0,  0, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(0, 1, F3_H,  32'h31, 32'h1234BEEF, 0,  0, 4'b0110, 32'h34BEEF00, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_H,  32'h31, 32'h0,        12, 0, 4'b0110, 32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF, 0));
    tbl.push_back(mkv(1, 0, F3_HU, 32'h31, 32'h0,        13, 0, 4'b0110, 32'h0,        4'b0000, 32'h0,        32'h0000BEEF, 0));
    tbl.push_back(mkv(0, 1, 3'b100, 32'h30, 32'hFFFFFFFF, 5, 0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, 3'b011, 32'h10, 32'h0,        3,  0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 1, F3_W,  32'h10, 32'h0,        4,  0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(0, 0, F3_W,  32'h10, 32'h0,        6,  0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(1, 0, F3_W,  32'h30, 32'h0,        14, 0, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'h00BEEF00, 0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h40, 32'h01020304, 0,  0, 4'b1111, 32'h01020304, 4'b0000, 32'h0,        32'h0,        0));
    tbl.push_back(mkv(0, 1, F3_W,  32'h44, 32'h0,        0,  0, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'h0,        0));

    at_neg();
    chk("rst_valid", 32'(respValid), 32'd0);
    chk("rst_regwrite", 32'(respRegWrite), 32'd0);
    chk("rst_fault", 32'(respFault), 32'd0);
    chk("rst_rd", 32'(respRd), 32'd0);
    chk("rst_data", respData, 32'd0);
    chk("rst_ready", 32'(reqReady), 32'd1);
    at_pos();
    reset = 1'b0;
    at_pos();

    foreach (tbl[i]) issue(tbl[i]);

    // Four aligned loads back to back: no stall, one response per cycle.
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: v = mkv(1, 0, F3_W, 32'h10, 32'h0, 20, 0, 4'b1111, 32'h0, 4'b0, 32'h0, 32'h000000CD, 0);
        1: v = mkv(1, 0, F3_W, 32'h0C, 32'h0, 21, 0, 4'b1111, 32'h0, 4'b0, 32'h0, 32'hAB000000, 0);
        2: v = mkv(1, 0, F3_W, 32'h30, 32'h0, 22, 0, 4'b1111, 32'h0, 4'b0, 32'h0, 32'h00BEEF00, 0);
        default: v = mkv(1, 0, F3_B, 32'h31, 32'h0, 23, 0, 4'b0010, 32'h0, 4'b0, 32'h0, 32'hFFFFFFEF, 0);
      endcase
      drive(v);
      expect_resp(v);
      at_neg();
      chk("b2b_ready", 32'(reqReady), 32'd1);
      if (k > 0) chk("b2b_resp_pulse", 32'(respValid), 32'd1);
      at_pos();
    end
    idle_cycle();

    // Crossing store abandoned by reset during its second beat.
    drive(mkv(0, 1, F3_W, 32'h42, 32'hAABBCCDD, 0, 1, 4'b1100, 32'h0, 4'b0011, 32'h0, 32'h0, 0));
    at_neg();
    chk("rst2_b1_be", 32'(memoryByteEnable), 32'b1100);
    at_pos();
    chk("rst2_in_second", 32'(reqReady), 32'd0);
    reset = 1'b1;
    reqValid = 1'b0; reqIsStore = 1'b0;
    #1;
    chk("rst2_ready", 32'(reqReady), 32'd1);
    at_neg();
    chk("rst2_valid", 32'(respValid), 32'd0);
    chk("rst2_wr_en", 32'(memoryWriteEnable), 32'd0);
    at_pos();
    reset = 1'b0;
    at_pos();
    issue(mkv(1, 0, F3_W, 32'h44, 32'h0, 24, 0, 4'b1111, 32'h0, 4'b0, 32'h0, 32'h00000000, 0));
    issue(mkv(1, 0, F3_W, 32'h40, 32'h0, 25, 0, 4'b1111, 32'h0, 4'b0, 32'h0, 32'hCCDD0304, 0));
    idle_cycle();
    idle_cycle();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
